// File: rtl/q_proj_tile_scheduler.sv
// q_proj_tile_scheduler
//   Sequences Q-projection tiles across NUM_LANES compute lanes. For each tile
//   it pulses lane_start on all lanes and waits at a barrier until every lane
//   has pulsed lane_done. It then pulses commit, pulses advance one cycle later,
//   and moves on to the next tile. A run ends with a one-cycle finished pulse.
//
// Optional feature: define QPS_TIMEOUT_EN to enable the barrier watchdog.
//   When enabled, TIMEOUT_CYCLES WAIT cycles without a barrier move the FSM to
//   ERROR. ERROR holds err and busy high until rst.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   start      run request, sampled only in IDLE
//   cfg_tiles  tiles per run, sampled with start, saturates to MAX_TILES
//   lane_start one-cycle start pulse to every lane
//   lane_done  per-lane completion pulses, any order, any cycle
//   tile_idx   index of the tile in flight
//   commit     barrier met for tile_idx
//   advance    one cycle after commit
//   busy       first ISSUE cycle through last ADVANCE cycle (and ERROR)
//   finished   one-cycle end-of-run pulse
//   err        sticky watchdog flag (constant 0 without QPS_TIMEOUT_EN)
module q_proj_tile_scheduler #(
  parameter int NUM_LANES      = 4,
  parameter int MAX_TILES      = 16,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int TILE_W = $clog2(MAX_TILES),
  localparam int CNT_W  = $clog2(MAX_TILES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     cfg_tiles,
  output logic [NUM_LANES-1:0] lane_start,
  input  logic [NUM_LANES-1:0] lane_done,
  output logic [TILE_W-1:0]    tile_idx,
  output logic                 commit,
  output logic                 advance,
  output logic                 busy,
  output logic                 finished,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMMIT  = 3'd3,
    S_ADVANCE = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t               state_r, state_s;
  logic [NUM_LANES-1:0] seen_r, seen_s;
  logic [TILE_W-1:0]    tile_idx_r, tile_idx_s;
  logic [CNT_W-1:0]     cfg_r, cfg_s;
  logic                 fin_s;
  logic                 all_done_s;
  logic                 last_s;
  logic [NUM_LANES-1:0] lane_start_r;
  logic                 commit_r, advance_r, busy_r, finished_r;

`ifdef QPS_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCNT_W-1:0]    wait_cnt_r, wait_cnt_s;
  logic                 err_r;
`else
  // TIMEOUT_CYCLES has no role without the watchdog.
  logic [31:0]          timeout_unused_s;
  assign timeout_unused_s = 32'(TIMEOUT_CYCLES);
`endif

  // A lane pulsing in the same cycle as the last missing bit still completes the barrier.
  assign all_done_s = &(seen_r | lane_done);
  assign last_s     = (CNT_W'(tile_idx_r) == (cfg_r - CNT_W'(1)));

  // Next-state and next-register computation.
  always_comb begin
    state_s    = state_r;
    seen_s     = seen_r;
    tile_idx_s = tile_idx_r;
    cfg_s      = cfg_r;
    fin_s      = 1'b0;
`ifdef QPS_TIMEOUT_EN
    wait_cnt_s = wait_cnt_r;
`endif
    case (state_r)
      S_IDLE: begin
        tile_idx_s = {TILE_W{1'b0}};
        if (start && (cfg_tiles != {CNT_W{1'b0}})) begin
          cfg_s   = (cfg_tiles > CNT_W'(MAX_TILES)) ? CNT_W'(MAX_TILES) : cfg_tiles;
          state_s = S_ISSUE;
        end else if (start) begin
          // Empty run: report completion without touching the lanes.
          fin_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        // lane_done during ISSUE is dropped; the barrier starts clean.
        seen_s  = {NUM_LANES{1'b0}};
`ifdef QPS_TIMEOUT_EN
        wait_cnt_s = {WCNT_W{1'b0}};
`endif
        state_s = S_WAIT;
      end
      S_WAIT: begin
        seen_s = seen_r | lane_done;
        if (all_done_s) begin
          state_s = S_COMMIT;
`ifdef QPS_TIMEOUT_EN
        end else if (wait_cnt_r == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_s = S_ERROR;
        end else begin
          wait_cnt_s = wait_cnt_r + WCNT_W'(1);
`else
        end else begin
          state_s = S_WAIT;
`endif
        end
      end
      S_COMMIT: begin
        // finished must line up with advance, so decide it one cycle early.
        fin_s   = last_s;
        state_s = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (last_s) begin
          tile_idx_s = {TILE_W{1'b0}};
          state_s    = S_IDLE;
        end else begin
          tile_idx_s = tile_idx_r + TILE_W'(1);
          state_s    = S_ISSUE;
        end
      end
      S_ERROR: begin
        state_s = S_ERROR;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      seen_r       <= {NUM_LANES{1'b0}};
      tile_idx_r   <= {TILE_W{1'b0}};
      cfg_r        <= {CNT_W{1'b0}};
      lane_start_r <= {NUM_LANES{1'b0}};
      commit_r     <= 1'b0;
      advance_r    <= 1'b0;
      busy_r       <= 1'b0;
      finished_r   <= 1'b0;
`ifdef QPS_TIMEOUT_EN
      wait_cnt_r   <= {WCNT_W{1'b0}};
      err_r        <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      seen_r       <= seen_s;
      tile_idx_r   <= tile_idx_s;
      cfg_r        <= cfg_s;
      lane_start_r <= {NUM_LANES{state_s == S_ISSUE}};
      commit_r     <= (state_s == S_COMMIT);
      advance_r    <= (state_s == S_ADVANCE);
      busy_r       <= (state_s != S_IDLE);
      finished_r   <= fin_s;
`ifdef QPS_TIMEOUT_EN
      wait_cnt_r   <= wait_cnt_s;
      err_r        <= (state_s == S_ERROR);
`endif
    end
  end

  assign lane_start = lane_start_r;
  assign tile_idx   = tile_idx_r;
  assign commit     = commit_r;
  assign advance    = advance_r;
  assign busy       = busy_r;
  assign finished   = finished_r;
`ifdef QPS_TIMEOUT_EN
  assign err        = err_r;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_q_proj_tile_scheduler.sv
module tb_q_proj_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] cfg_tiles;
  logic [3:0] lane_start;
  logic [3:0] lane_done;
  logic [3:0] tile_idx;
  logic       commit, advance, busy, finished, err;

  q_proj_tile_scheduler #(
    .NUM_LANES(4), .MAX_TILES(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_tiles(cfg_tiles),
    .lane_start(lane_start), .lane_done(lane_done), .tile_idx(tile_idx),
    .commit(commit), .advance(advance), .busy(busy), .finished(finished),
    .err(err)
  );

  always #5 clk = ~clk;

  // Expected output events: {lane_start, commit, advance, finished} at a cycle.
  typedef struct {
    int         cyc;
    logic [6:0] ev;
    logic [3:0] tile;
  } ev_t;

  typedef struct {
    logic       start;
    logic [4:0] cfg;
    logic [3:0] done;
    logic       busy;
    logic [3:0] tile;
  } vec_t;

  ev_t  sb[$];
  vec_t tbl [12];
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  logic exp_err = 1'b0;

  localparam logic [6:0] EV_LS  = 7'b1111000;
  localparam logic [6:0] EV_CM  = 7'b0000100;
  localparam logic [6:0] EV_AD  = 7'b0000010;
  localparam logic [6:0] EV_FN  = 7'b0000001;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [6:0] ev, input logic [3:0] t);
    ev_t e;
    e.cyc = c; e.ev = ev; e.tile = t;
    sb.push_back(e);
  endtask

  // Compare this cycle's outputs with the scoreboard front.
  task automatic observe();
    logic [6:0] obs;
    obs = {lane_start, commit, advance, finished};
    chk(err == exp_err, "err", int'(err), int'(exp_err));
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      chk(obs == sb[0].ev, "event", int'(obs), int'(sb[0].ev));
      chk(tile_idx == sb[0].tile, "event_tile", int'(tile_idx), int'(sb[0].tile));
      void'(sb.pop_front());
    end else begin
      chk(obs == 7'd0, "no_event", int'(obs), 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic idle_inputs();
    start = 1'b0; cfg_tiles = 5'd0; lane_done = 4'h0;
  endtask

  // Run with every lane done in the first WAIT cycle of every tile.
  task automatic run_all_done(input int cfg, input bit poke);
    int eff, c0, rel, t_exp;
    bit b_exp;
    eff = (cfg > 16) ? 16 : cfg;
    c0  = cyc;
    for (int k = 0; k < eff; k++) begin
      push(c0 + 1 + 4*k, EV_LS, 4'(k));
      push(c0 + 3 + 4*k, EV_CM, 4'(k));
      push(c0 + 4 + 4*k, (k == eff-1) ? (EV_AD | EV_FN) : EV_AD, 4'(k));
    end
    for (rel = 0; rel <= 4*eff + 1; rel++) begin
      b_exp = (rel >= 1) && (rel <= 4*eff);
      t_exp = b_exp ? (rel - 1) / 4 : 0;
      chk(busy == b_exp, "run_busy", int'(busy), int'(b_exp));
      chk(int'(tile_idx) == t_exp, "run_tile", int'(tile_idx), t_exp);
      idle_inputs();
      if (rel == 0) begin start = 1'b1; cfg_tiles = 5'(cfg); end
      if (poke && rel == 5) begin start = 1'b1; cfg_tiles = 5'd2; end
      if (rel >= 2 && ((rel - 2) % 4) == 0) lane_done = 4'hF;
      step();
    end
  endtask

  initial begin
    // Single tile, staggered lane_done.
    tbl[0]  = '{1'b1, 5'd1, 4'h0, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 5'd0, 4'h0, 1'b1, 4'd0};
    tbl[2]  = '{1'b0, 5'd0, 4'h0, 1'b1, 4'd0};
    tbl[3]  = '{1'b0, 5'd0, 4'h1, 1'b1, 4'd0};
    tbl[4]  = '{1'b0, 5'd0, 4'h0, 1'b1, 4'd0};
    tbl[5]  = '{1'b0, 5'd0, 4'h2, 1'b1, 4'd0};
    tbl[6]  = '{1'b0, 5'd0, 4'h4, 1'b1, 4'd0};
    tbl[7]  = '{1'b0, 5'd0, 4'h0, 1'b1, 4'd0};
    tbl[8]  = '{1'b0, 5'd0, 4'h8, 1'b1, 4'd0};
    tbl[9]  = '{1'b0, 5'd0, 4'h0, 1'b1, 4'd0};
    tbl[10] = '{1'b0, 5'd0, 4'h0, 1'b1, 4'd0};
    tbl[11] = '{1'b0, 5'd0, 4'h0, 1'b0, 4'd0};

    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(tile_idx == 4'd0, "reset_tile", int'(tile_idx), 0);
    step();

    // Test 1: table-driven single tile.
    begin
      int c0;
      c0 = cyc;
      push(c0 + 1, EV_LS, 4'd0);
      push(c0 + 9, EV_CM, 4'd0);
      push(c0 + 10, EV_AD | EV_FN, 4'd0);
      for (int r = 0; r < 12; r++) begin
        chk(busy == tbl[r].busy, "t1_busy", int'(busy), int'(tbl[r].busy));
        chk(tile_idx == tbl[r].tile, "t1_tile", int'(tile_idx), int'(tbl[r].tile));
        start = tbl[r].start; cfg_tiles = tbl[r].cfg; lane_done = tbl[r].done;
        step();
      end
    end

    // Test 2: three tiles, start poked while busy.
    run_all_done(3, 1'b1);
    idle_inputs();
    step();

    // Saturation: 31 requested tiles run as 16.
    run_all_done(31, 1'b0);
    idle_inputs();
    step();

    // Test 3: duplicates, lane3 late (its ISSUE-cycle pulse must not count).
    begin
      int c0;
      c0 = cyc;
      push(c0 + 1, EV_LS, 4'd0);
      push(c0 + 28, EV_CM, 4'd0);
      push(c0 + 29, EV_AD | EV_FN, 4'd0);
      for (int rel = 0; rel <= 30; rel++) begin
        idle_inputs();
        case (rel)
          0: begin start = 1'b1; cfg_tiles = 5'd1; end
          1: lane_done = 4'h8;
          2, 3, 5: lane_done = 4'h1;
          4: lane_done = 4'h2;
          6: lane_done = 4'h4;
          27: lane_done = 4'h8;
          default: lane_done = 4'h0;
        endcase
        if (rel == 28) chk(busy == 1'b1, "t3_busy", int'(busy), 1);
        step();
      end
    end

    // Test 4: zero tiles; lane_done in IDLE is ignored.
    begin
      int c0;
      c0 = cyc;
      push(c0 + 1, EV_FN, 4'd0);
      idle_inputs();
      start = 1'b1;
      lane_done = 4'hF;
      step();
      idle_inputs();
      chk(busy == 1'b0, "t4_busy", int'(busy), 0);
      step();
      step();
    end

    // Test 5: reset mid-WAIT, then a fresh run ignores pre-reset dones.
    begin
      int c0;
      c0 = cyc;
      push(c0 + 1, EV_LS, 4'd0);
      for (int rel = 0; rel <= 4; rel++) begin
        idle_inputs();
        if (rel == 0) begin start = 1'b1; cfg_tiles = 5'd2; end
        if (rel == 2) lane_done = 4'h1;
        if (rel == 3) lane_done = 4'h2;
        if (rel == 4) rst = 1'b1;
        step();
      end
      rst = 1'b0;
      chk(busy == 1'b0, "t5_busy", int'(busy), 0);
      chk(tile_idx == 4'd0, "t5_tile", int'(tile_idx), 0);
      c0 = cyc;
      push(c0 + 2, EV_LS, 4'd0);
      push(c0 + 8, EV_CM, 4'd0);
      push(c0 + 9, EV_AD | EV_FN, 4'd0);
      for (int rel = 0; rel <= 10; rel++) begin
        idle_inputs();
        if (rel == 1) begin start = 1'b1; cfg_tiles = 5'd1; end
        if (rel == 3) lane_done = 4'hC;
        if (rel == 7) lane_done = 4'h3;
        step();
      end
    end

`ifdef QPS_TIMEOUT_EN
    // Test 6: watchdog fires after 8 WAIT cycles, held until rst.
    begin
      int c0;
      c0 = cyc;
      push(c0 + 1, EV_LS, 4'd0);
      for (int rel = 0; rel <= 15; rel++) begin
        idle_inputs();
        if (rel == 0) begin start = 1'b1; cfg_tiles = 5'd1; end
        if (rel == 3) lane_done = 4'hB;
        if (rel == 11) begin start = 1'b1; cfg_tiles = 5'd1; end
        if (rel >= 10) chk(busy == 1'b1, "t6_busy", int'(busy), 1);
        exp_err = (rel + 1 >= 10);
        step();
      end
      idle_inputs();
      rst = 1'b1;
      exp_err = 1'b0;
      step();
      rst = 1'b0;
      // Barrier completing on the final counted WAIT cycle wins.
      c0 = cyc;
      push(c0 + 1, EV_LS, 4'd0);
      push(c0 + 10, EV_CM, 4'd0);
      push(c0 + 11, EV_AD | EV_FN, 4'd0);
      for (int rel = 0; rel <= 12; rel++) begin
        idle_inputs();
        if (rel == 0) begin start = 1'b1; cfg_tiles = 5'd1; end
        if (rel == 2) lane_done = 4'h3;
        if (rel == 9) lane_done = 4'hC;
        step();
      end
    end
`endif

    idle_inputs();
    step();
    chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
